// File: rtl/project_pkg.sv
// Shared memory-subsystem types: the word type, memory geometry and arbiter FSM states.
package project_pkg;

    localparam int unsigned word_size = 16;
    typedef logic [word_size-1:0] word;

    // Number of words in the single-port memory; valid addresses are 0..mem_size-1.
    localparam int unsigned mem_size = 32;

    localparam int MAX_ARB_PORTS = 8;

    typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: first eligible port at or after ptr, wrapping to 0.
// Returns the winner as a one-hot grant and as a binary index.
module arb_pick
    import project_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int IW      = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] eligible,
    input  logic [IW-1:0]      ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            j = (int'(ptr) + i) % N_PORTS;
            if (!found && eligible[j]) begin
                found    = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter in front of the single-port word memory; each grant is IDLE -> ACCESS -> ack.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module mem_arbiter
    import project_pkg::*;
#(
    parameter int N_PORTS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] req_we,
    input  word  [N_PORTS-1:0] req_addr,
    input  word  [N_PORTS-1:0] req_wdata,
    output logic [N_PORTS-1:0] ack,
    output word                rdata,
    output logic               err,
    output logic               mem_we,
    output word                mem_a,
    output word                mem_wd,
    input  word                mem_rd
);

    localparam int IW = $clog2(N_PORTS);

    arb_state_e         state, state_nx;
    logic [N_PORTS-1:0] eligible, pick_gnt, lat_gnt;
    logic [IW-1:0]      pick_idx, ptr;
    logic               pick_any, lat_we, lat_err;
    word                lat_addr, lat_wdata;

    // A port being acked this cycle must not be re-granted off its stale request.
    assign eligible = req & ~ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] lat_idx, rr_ptr;

    assign ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_idx <= '0;
            rr_ptr  <= '0;
        end else if (state == ARB_IDLE && pick_any) begin
            lat_idx <= pick_idx;
        end else if (state == ARB_ACCESS) begin
            rr_ptr <= (lat_idx == IW'(N_PORTS - 1)) ? '0 : lat_idx + 1'b1;
        end
    end
`else
    logic unused_idx;

    assign ptr        = '0;
    assign unused_idx = ^pick_idx;
`endif

    arb_pick #(.N_PORTS(N_PORTS)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (pick_gnt),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        mem_a    = '0;
        mem_wd   = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_nx = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                state_nx = ARB_IDLE;
                mem_a    = lat_addr;
                mem_wd   = lat_wdata;
                // rst gating keeps a reset landing mid-transaction from committing the write.
                mem_we   = lat_we & ~lat_err & ~rst;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            lat_gnt   <= '0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            ack <= '0;
            if (state == ARB_IDLE && pick_any) begin
                lat_gnt   <= pick_gnt;
                lat_we    <= req_we[pick_idx];
                lat_addr  <= req_addr[pick_idx];
                lat_wdata <= req_wdata[pick_idx];
                // Full-width compare: high address bits must not alias into the array.
                lat_err   <= (32'(req_addr[pick_idx]) >= mem_size);
            end
            if (state == ARB_ACCESS) begin
                ack <= lat_gnt;
                err <= lat_err;
                if (!(lat_we || lat_err)) rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (3 ports) with a behavioural word memory:
// directed reset/range/contention cases plus randomized multi-port traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import project_pkg::*;

    localparam int NP  = 3;
    localparam int AW  = $clog2(mem_size);
    localparam int NTX = 25;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] req_we = '0;
    word  [NP-1:0] req_addr = '0;
    word  [NP-1:0] req_wdata = '0;
    logic [NP-1:0] ack;
    word           rdata;
    logic          err;
    logic          mem_we;
    word           mem_a, mem_wd, mem_rd;

    mem_arbiter #(.N_PORTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Memory under the arbiter: combinational read, write on the clock edge.
    word mem [mem_size] = '{default: '0};
    assign mem_rd = (32'(mem_a) < mem_size) ? mem[mem_a[AW-1:0]] : 16'hDEAD;
    always @(posedge clk) if (mem_we && 32'(mem_a) < mem_size) mem[mem_a[AW-1:0]] <= mem_wd;

    // Reference: what memory should hold, and per-port queues of expected completions.
    typedef struct packed {
        logic upd;
        word  rd;
        logic err;
    } exp_t;

    word  ref_mem [mem_size] = '{default: '0};
    exp_t q0[$], q1[$], q2[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_txn(input int p, input logic we, input word addr, input word wd);
        exp_t e;
        e.err = (32'(addr) >= mem_size);
        e.upd = !we && !e.err;
        e.rd  = e.upd ? ref_mem[addr[AW-1:0]] : '0;
        if (we && !e.err) ref_mem[addr[AW-1:0]] = wd;
        case (p)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Monitor: every cycle, away from the active edge.
    word last_rd  = '0;
    bit  prev_rst = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   p;
        bit   got;
        e   = '0;
        got = 1'b1;
        chk("ack_onehot0", 32'($onehot0(ack)), 1);
        if (mem_we) chk("mem_we_in_range", 32'(32'(mem_a) < mem_size), 1);
        if (rst) begin
            chk("rst_ack", 32'(ack), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            if (prev_rst) chk("rst_rdata", 32'(rdata), 0);
            last_rd = '0;
        end else if (ack != '0) begin
            p = ack[0] ? 0 : (ack[1] ? 1 : 2);
            case (p)
                0:       if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
                1:       if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
                default: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
            endcase
            if (!got) begin
                chk("unexpected_ack", 32'(ack), 0);
            end else begin
                chk("err", 32'(err), 32'(e.err));
                if (e.upd) chk("rdata", 32'(rdata), 32'(e.rd));
                else       chk("rdata_unchanged", 32'(rdata), 32'(last_rd));
                if (e.upd) last_rd = e.rd;
            end
        end else begin
            chk("rdata_hold", 32'(rdata), 32'(last_rd));
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on port p; exp_lat > 0 also checks cycles from req to ack.
    task automatic single(input int p, input logic we, input word addr, input word wd, input int exp_lat);
        int n;
        n = 0;
        expect_txn(p, we, addr, wd);
        req_we[p] = we; req_addr[p] = addr; req_wdata[p] = wd; req[p] = 1'b1;
        do begin
            tick();
            n++;
        end while (!ack[p] && n < 20);
        req[p] = 1'b0;
        chk("ack_seen", 32'(ack[p]), 1);
        if (exp_lat > 0) chk("latency", n, exp_lat);
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_ord[$];
        int got_ord[$];
        int rem[NP];
        int busy[NP];
        int cyc, ptr, last, w, c, k, prev, r;
        word a;

        // Reset held with every port requesting: nothing may be granted.
        req = '1;
        tick();
        tick();
        req = '0;
        rst = 1'b0;
        repeat (3) tick();
        chk("post_reset_idle_ack", 32'(ack), 0);

        // Single write then read back.
        single(0, 1'b1, 16'd5, 16'h00A5, 2);
        single(0, 1'b0, 16'd5, 16'h0000, 2);
        chk("readback_a5", 32'(rdata), 32'h00A5);

        // Reset during ACCESS of a write: no write, no ack.
        req_we[0] = 1'b1; req_addr[0] = 16'd3; req_wdata[0] = 16'h0033; req[0] = 1'b1;
        tick();
        rst = 1'b1;
        req[0] = 1'b0;
        #1;
        chk("mid_rst_mem_we", 32'(mem_we), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_mem3", 32'(mem[3]), 32'(ref_mem[3]));
        single(0, 1'b0, 16'd3, 16'h0000, 2);

        // Contention: all ports hold reads. The port acked in a cycle sits out that
        // cycle's pick, so expected order follows from eligibility plus the priority rule.
        pulse_reset();
        ptr = 0; last = -1;
        for (int n = 0; n < 6; n++) begin
            w = -1;
            for (int i = 0; i < NP; i++) begin
                c = RR ? (ptr + i) % NP : i;
                if (w < 0 && c != last) w = c;
            end
            exp_ord.push_back(w);
            last = w;
            ptr = (w + 1) % NP;
        end
        foreach (exp_ord[i]) expect_txn(exp_ord[i], 1'b0, word'(exp_ord[i] == 0 ? 1 : exp_ord[i] == 1 ? 2 : 4), '0);
        req_we = '0;
        req_addr[0] = 16'd1; req_addr[1] = 16'd2; req_addr[2] = 16'd4;
        req = '1;
        cyc = 0;
        while (got_ord.size() < 6 && cyc < 60) begin
            tick();
            cyc++;
            if (ack != '0) got_ord.push_back(ack[0] ? 0 : (ack[1] ? 1 : 2));
        end
        req = '0;
        chk("contention_acks", got_ord.size(), 6);
        foreach (got_ord[i]) chk($sformatf("contention_order%0d", i), got_ord[i], exp_ord[i]);
        repeat (3) tick();

        // Out-of-range accesses: flagged, no write, rdata untouched.
        single(1, 1'b1, word'(mem_size), 16'h00FF, 2);
        single(1, 1'b0, word'(mem_size - 1), 16'h0000, 2);
        single(1, 1'b0, 16'h8001, 16'h0000, 2);
        single(2, 1'b1, 16'hFFFF, 16'h1234, 2);
        chk("oor_no_alias_mem1", 32'(mem[1]), 32'(ref_mem[1]));

        // Back-to-back reads on one port with req held: preload i at addr i first.
        for (int i = 0; i < 10; i++) single(0, 1'b1, word'(i), word'(i), 0);
        expect_txn(0, 1'b0, 16'd0, '0);
        req_we[0] = 1'b0; req_addr[0] = 16'd0; req[0] = 1'b1;
        k = 0; cyc = 0; prev = 0;
        while (k < 10 && cyc < 100) begin
            tick();
            cyc++;
            if (ack[0]) begin
                // Ack cycle is an IDLE cycle where this port is ineligible, so a lone
                // requester completes every 3 cycles.
                if (k > 0) chk("b2b_spacing", cyc - prev, 3);
                prev = cyc;
                k++;
                if (k < 10) begin
                    req_addr[0] = word'(k);
                    expect_txn(0, 1'b0, word'(k), '0);
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        req[0] = 1'b0;
        chk("b2b_count", k, 10);
        repeat (6) tick();

        // Random traffic: each port keeps to its own address partition so its expected
        // results depend only on its own order.
        foreach (rem[i])  rem[i] = NTX;
        foreach (busy[i]) busy[i] = 0;
        cyc = 0;
        while ((rem[0] + rem[1] + rem[2] + busy[0] + busy[1] + busy[2]) > 0 && cyc < 3000) begin
            tick();
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (busy[p] != 0 && ack[p]) begin
                    busy[p] = 0;
                    req[p] = 1'b0;
                end
                if (busy[p] == 0 && rem[p] > 0 && $urandom_range(0, 3) != 0) begin
                    r = int'($urandom_range(0, 7));
                    if (r == 0)      a = word'(mem_size + $urandom_range(0, 100));
                    else if (r == 1) a = word'($urandom) | 16'h8000;
                    else             a = word'(p + NP * int'($urandom_range(0, (mem_size - 1 - p) / NP)));
                    req_we[p] = 1'($urandom_range(0, 1));
                    req_addr[p] = a;
                    req_wdata[p] = word'($urandom);
                    expect_txn(p, req_we[p], a, req_wdata[p]);
                    req[p] = 1'b1;
                    busy[p] = 1;
                    rem[p]--;
                end
            end
        end
        req = '0;
        chk("random_done", 32'(cyc < 3000), 1);
        repeat (5) tick();
        chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
